mem_path_arbiter: RTL
=====================

Name: mem_path_arbiter

Overview:
- Sequences the shared memory read/write path (memory port, MBR capture, BR load) for the 16-bit CPU.
- Shares the path between two requesters: instruction fetch (IF) and execute-stage data access (EX).
- Generates the MBR-load and BR-load strobes (BR load is control word bit 12) and returns read data with a one-cycle done pulse.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, data width
MEM_LAT, 2, memory read latency in cycles after the address cycle (legal 0..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch read request; held until if_done
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_done  out  1  one-cycle pulse; fetch data valid on rdata
ex_req  in  1  data access request; held until ex_done
ex_we  in  1  1 = write, 0 = read; stable while ex_req is high
ex_addr  in  ADDR_W  data address
ex_wdata  in  DATA_W  write data
ex_done  out  1  one-cycle pulse; EX transaction complete
rdata  out  DATA_W  captured read data; holds until next capture
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the address cycle
mbr_load  out  1  MBR capture strobe
br_load  out  1  BR load strobe (control bit 12)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (async, immediate): state=IDLE; all strobes, done pulses and busy = 0; mem_addr, mem_wdata and rdata = 0; last_grant=EX; wait counter = 0.
- States: IDLE, ADDR, WAIT, CAP, BRLD, DONE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - If any request is pending, register the grant owner and its address/we/wdata, then go to ADDR next cycle.
- Arbitration is round-robin:
  - On a simultaneous request, the side not in last_grant wins.
  - last_grant updates on every grant.
  - A single requester always wins.
- ADDR (1 cycle): mem_en=1; mem_addr=latched address; mem_we=1 only for an EX write; mem_wdata=latched wdata.
  - Write: go to DONE.
  - Read with MEM_LAT=0: go to CAP.
  - Otherwise: go to WAIT with counter loaded to MEM_LAT-1.
- WAIT: mem_en=1, address held. Counter decrements; when it reaches 0, go to CAP.
- CAP (1 cycle): mbr_load=1; rdata <= mem_rdata.
  - EX owner: go to BRLD.
  - IF owner: go to DONE.
- BRLD (1 cycle): br_load=1; then go to DONE. Only EX reads load BR.
- DONE (1 cycle): pulse the owner's done signal; return to IDLE.
- Latencies from the IDLE grant cycle to the done pulse:
  - Write: 2 cycles.
  - IF read: MEM_LAT+3 cycles.
  - EX read: MEM_LAT+4 cycles.
- Request handling:
  - A requester still asserting req in the IDLE cycle after its done pulse is treated as a new request.
  - Dropping req mid-transaction does not abort it; the transaction completes and done still pulses.
  - Request inputs are ignored outside IDLE.
  - Address/data are latched at grant, so input changes after grant have no effect.
- Outputs are registered; no combinational path from req to mem_*.
- A reset asserted mid-transaction aborts it: no done pulse, and mem_en deasserts asynchronously.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: EX always wins a simultaneous request; last_grant is unused.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- MEM_LAT=2, if_req=1, if_addr=8'h10, memory returns 16'hA5A5 → mem_en high for 3 cycles (ADDR + 2 WAIT); mbr_load pulse; if_done pulse 5 cycles after grant; rdata=16'hA5A5; br_load never asserted.
- ex_req=1, ex_we=0, ex_addr=8'h20, memory returns 16'h1234 → mbr_load then br_load on consecutive cycles; ex_done pulses 6 cycles after grant; rdata=16'h1234.
- ex_we=1, ex_addr=8'h30, ex_wdata=16'hBEEF → exactly one cycle with mem_en=mem_we=1, mem_addr=8'h30, mem_wdata=16'hBEEF; ex_done next cycle; no mbr_load or br_load.
- Both requests held high continuously after reset → grants alternate IF, EX, IF, EX. With ARB_FIXED_PRIO_EN defined, the same stimulus yields EX on every grant.
- MEM_LAT=0 → IF read completes with if_done 3 cycles after grant; rdata is captured in the cycle after ADDR.
- rst asserted during WAIT of an EX read → mem_en, busy and all strobes are 0 immediately; no ex_done; after release, a pending if_req is granted first (last_grant=EX).

Source files
------------

// File: rtl/mem_path_arbiter.sv
// mem_path_arbiter: sequences the shared memory read/write path for the 16-bit CPU.
// Two requesters share the path: instruction fetch (IF) and execute-stage data access (EX).
// Per transaction it drives the memory port, the MBR capture strobe and the BR load strobe
// (control word bit 12), and pulses the owner's done signal for one cycle.
// Optional build macro ARB_FIXED_PRIO_EN: when defined, EX always wins a simultaneous
// request. When undefined (default), simultaneous requests are granted round-robin.
module mem_path_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mbr_load,
    output logic              br_load,
    output logic              busy
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LAT_LOAD = (MEM_LAT == 0) ? 0 : MEM_LAT - 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_BRLD = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               owner_ex_q;
    logic               we_q;
    logic [CNT_W-1:0]   cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    logic               last_ex_q;
`endif

    logic               any_req;
    logic               grant_ex;
    logic               grant_now;
    logic               owner_ex_d;
    logic               we_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               mem_en_d;
    logic               mem_we_d;
    logic               mbr_load_d;
    logic               br_load_d;
    logic               busy_d;
    logic               if_done_d;
    logic               ex_done_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic [DATA_W-1:0]  rdata_d;

    // State register plus registered outputs and transaction context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_ex_q <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_ex_q  <= 1'b1;
`endif
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mbr_load   <= 1'b0;
            br_load    <= 1'b0;
            busy       <= 1'b0;
            if_done    <= 1'b0;
            ex_done    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state_q    <= state_d;
            owner_ex_q <= owner_ex_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            if (grant_now) begin
                last_ex_q <= grant_ex;
            end
`endif
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mbr_load   <= mbr_load_d;
            br_load    <= br_load_d;
            busy       <= busy_d;
            if_done    <= if_done_d;
            ex_done    <= ex_done_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            rdata      <= rdata_d;
        end
    end

    // Arbitration and next-state selection
    always_comb begin
        any_req = if_req | ex_req;
`ifdef ARB_FIXED_PRIO_EN
        grant_ex = ex_req;
`else
        grant_ex = ex_req & (~if_req | ~last_ex_q);
`endif
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else if (MEM_LAT == 0) begin
                    state_d = S_CAP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAP;
                end
            end
            S_CAP:   state_d = owner_ex_q ? S_BRLD : S_DONE;
            S_BRLD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        grant_now   = (state_q == S_IDLE) && any_req;
        owner_ex_d  = grant_now ? grant_ex : owner_ex_q;
        we_d        = grant_now ? (grant_ex & ex_we) : we_q;

        cnt_d = cnt_q;
        if (state_q == S_ADDR) begin
            cnt_d = CNT_W'(LAT_LOAD);
        end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        mem_en_d    = (state_d == S_ADDR) || (state_d == S_WAIT);
        mem_we_d    = (state_d == S_ADDR) && we_d;
        mbr_load_d  = (state_d == S_CAP);
        br_load_d   = (state_d == S_BRLD);
        busy_d      = (state_d != S_IDLE);
        if_done_d   = (state_d == S_DONE) && !owner_ex_d;
        ex_done_d   = (state_d == S_DONE) && owner_ex_d;

        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if (grant_now) begin
            mem_addr_d  = grant_ex ? ex_addr : if_addr;
            mem_wdata_d = grant_ex ? ex_wdata : '0;
        end

        rdata_d = (state_q == S_CAP) ? mem_rdata : rdata;
    end

endmodule
